// File: rtl/cart_bus_sampler.sv
// cart_bus_sampler: brings the asynchronous cartridge bus (select, read strobe,
// address) into the SClk domain, qualifies each console read cycle and emits
// exactly one registered AddrValid pulse per accepted read with the latched
// address split into AddrLo (A7..A0) and AddrHi (A19..A16).
module cart_bus_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 2,
  parameter int CNT_W       = 8
) (
  input  logic             SClk,
  input  logic             Reset,
  input  logic             nSel,
  input  logic             nOE,
  input  logic [19:0]      AddrIn,
  output logic [7:0]       AddrLo,
  output logic [3:0]       AddrHi,
  output logic             AddrValid,
  output logic             CycleActive,
  output logic [CNT_W-1:0] ReadCount,
  output logic [CNT_W-1:0] GlitchCount
);

  localparam int LOW_W   = (MIN_LOW < 2) ? 1 : $clog2(MIN_LOW + 1);
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [2:0] {
    ST_RELEASE,
    ST_IDLE,
    ST_QUALIFY,
    ST_ACCEPT,
    ST_HOLD
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers: one flop per stage per signal, reset to the inactive bus.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic        sel_reg;
      logic        oe_reg;
      logic [19:0] addr_reg;
      if (gi == 0) begin : g_first
        // First stage samples the raw asynchronous pins.
        always_ff @(posedge SClk) begin
          if (Reset) begin
            sel_reg  <= 1'b1;
            oe_reg   <= 1'b1;
            addr_reg <= '0;
          end else begin
            sel_reg  <= nSel;
            oe_reg   <= nOE;
            addr_reg <= AddrIn;
          end
        end
      end else begin : g_next
        // Later stages shift the previous stage along the chain.
        always_ff @(posedge SClk) begin
          if (Reset) begin
            sel_reg  <= 1'b1;
            oe_reg   <= 1'b1;
            addr_reg <= '0;
          end else begin
            sel_reg  <= g_sync[gi-1].sel_reg;
            oe_reg   <= g_sync[gi-1].oe_reg;
            addr_reg <= g_sync[gi-1].addr_reg;
          end
        end
      end
    end
  endgenerate

  logic        sel_s;
  logic        oe_s;
  logic [19:0] addr_s;
  logic        rd;

  assign sel_s  = g_sync[SYNC_STAGES-1].sel_reg;
  assign oe_s   = g_sync[SYNC_STAGES-1].oe_reg;
  assign addr_s = g_sync[SYNC_STAGES-1].addr_reg;
  assign rd     = ~sel_s & ~oe_s;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             state_reg,   state_next;
  logic [LOW_W-1:0]   low_cnt_reg, low_cnt_next;
  logic [FLUSH_W-1:0] flush_reg,   flush_next;
  logic [19:0]        cand_reg,    cand_next;
  logic [7:0]         addr_lo_reg, addr_lo_next;
  logic [3:0]         addr_hi_reg, addr_hi_next;
  logic               valid_reg,   valid_next;
  logic               active_reg,  active_next;
  logic [CNT_W-1:0]   read_cnt_reg,   read_cnt_next;
  logic [CNT_W-1:0]   glitch_cnt_reg, glitch_cnt_next;

  logic               do_accept;
  logic [19:0]        accept_addr;

  // Next-state and output logic. Outputs are computed on the transition into
  // ACCEPT so that AddrValid is high during the ACCEPT cycle itself.
  always_comb begin
    state_next      = state_reg;
    low_cnt_next    = low_cnt_reg;
    flush_next      = flush_reg;
    cand_next       = cand_reg;
    addr_lo_next    = addr_lo_reg;
    addr_hi_next    = addr_hi_reg;
    valid_next      = 1'b0;
    active_next     = active_reg;
    read_cnt_next   = read_cnt_reg;
    glitch_cnt_next = glitch_cnt_reg;
    do_accept       = 1'b0;
    accept_addr     = cand_reg;

    case (state_reg)
      ST_RELEASE: begin
        // The synchronisers come out of reset showing an idle bus, so their
        // output is only trusted once the chain holds post-reset samples.
        // Without this, a strobe held low across Reset would be accepted.
        if (flush_reg != FLUSH_W'(SYNC_STAGES)) begin
          flush_next = flush_reg + 1'b1;
        end else if (!rd) begin
          state_next = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (rd) begin
          if (MIN_LOW <= 1) begin
            do_accept   = 1'b1;
            accept_addr = addr_s;
          end else begin
            low_cnt_next = LOW_W'(1);
            cand_next    = addr_s;
            state_next   = ST_QUALIFY;
          end
        end
      end

      ST_QUALIFY: begin
        if (!rd) begin
          if (glitch_cnt_reg != '1) begin
            glitch_cnt_next = glitch_cnt_reg + 1'b1;
          end
          state_next = ST_IDLE;
        end else if (addr_s != cand_reg) begin
          // Address still settling: restart qualification, not a glitch.
          cand_next    = addr_s;
          low_cnt_next = LOW_W'(1);
        end else if (int'(low_cnt_reg) + 1 >= MIN_LOW) begin
          // This cycle is the MIN_LOW-th stable low cycle.
          do_accept   = 1'b1;
          accept_addr = cand_reg;
        end else begin
          low_cnt_next = low_cnt_reg + 1'b1;
        end
      end

      ST_ACCEPT: begin
        state_next = ST_HOLD;
      end

      ST_HOLD: begin
        // Address changes are ignored here: one strobe per read cycle.
        if (!rd) begin
          active_next = 1'b0;
          state_next  = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_RELEASE;
      end
    endcase

    if (do_accept) begin
      addr_lo_next = accept_addr[7:0];
      addr_hi_next = accept_addr[19:16];
      valid_next   = 1'b1;
      active_next  = 1'b1;
      if (read_cnt_reg != '1) begin
        read_cnt_next = read_cnt_reg + 1'b1;
      end
      state_next = ST_ACCEPT;
    end
  end

  // State register and registered outputs; Reset wins over any bus activity.
  always_ff @(posedge SClk) begin
    if (Reset) begin
      state_reg      <= ST_RELEASE;
      low_cnt_reg    <= '0;
      flush_reg      <= '0;
      cand_reg       <= '0;
      addr_lo_reg    <= '0;
      addr_hi_reg    <= '0;
      valid_reg      <= 1'b0;
      active_reg     <= 1'b0;
      read_cnt_reg   <= '0;
      glitch_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      low_cnt_reg    <= low_cnt_next;
      flush_reg      <= flush_next;
      cand_reg       <= cand_next;
      addr_lo_reg    <= addr_lo_next;
      addr_hi_reg    <= addr_hi_next;
      valid_reg      <= valid_next;
      active_reg     <= active_next;
      read_cnt_reg   <= read_cnt_next;
      glitch_cnt_reg <= glitch_cnt_next;
    end
  end

  assign AddrLo      = addr_lo_reg;
  assign AddrHi      = addr_hi_reg;
  assign AddrValid   = valid_reg;
  assign CycleActive = active_reg;
  assign ReadCount   = read_cnt_reg;
  assign GlitchCount = glitch_cnt_reg;

endmodule

// File: tb/tb_cart_bus_sampler.sv
// Directed testbench for cart_bus_sampler (SYNC_STAGES=2, MIN_LOW=2, CNT_W=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_cart_bus_sampler;

  logic        SClk;
  logic        Reset;
  logic        nSel;
  logic        nOE;
  logic [19:0] AddrIn;
  logic [7:0]  AddrLo;
  logic [3:0]  AddrHi;
  logic        AddrValid;
  logic        CycleActive;
  logic [7:0]  ReadCount;
  logic [7:0]  GlitchCount;

  int n_checks    = 0;
  int n_pass      = 0;
  int pulse_cnt   = 0;
  int consec_err  = 0;
  logic prev_valid = 1'b0;

  cart_bus_sampler #(
    .SYNC_STAGES(2),
    .MIN_LOW    (2),
    .CNT_W      (8)
  ) dut (
    .SClk       (SClk),
    .Reset      (Reset),
    .nSel       (nSel),
    .nOE        (nOE),
    .AddrIn     (AddrIn),
    .AddrLo     (AddrLo),
    .AddrHi     (AddrHi),
    .AddrValid  (AddrValid),
    .CycleActive(CycleActive),
    .ReadCount  (ReadCount),
    .GlitchCount(GlitchCount)
  );

  initial SClk = 1'b0;
  always #5 SClk = ~SClk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: advance past the edge, then tally AddrValid pulses.
  task automatic tick();
    @(posedge SClk);
    #1;
    if (AddrValid) begin
      pulse_cnt++;
      if (prev_valid) consec_err++;
    end
    prev_valid = AddrValid;
  endtask

  // Run n cycles; report the first cycle (1-based) with AddrValid and pulse count.
  task automatic watch(input int n, output int first_k, output int cnt);
    int p0;
    p0 = pulse_cnt;
    first_k = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (AddrValid && first_k == 0) first_k = k;
    end
    cnt = pulse_cnt - p0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_lo"},     AddrLo,      0);
    check_val({tag, "_hi"},     AddrHi,      0);
    check_val({tag, "_valid"},  AddrValid,   0);
    check_val({tag, "_active"}, CycleActive, 0);
    check_val({tag, "_rdcnt"},  ReadCount,   0);
    check_val({tag, "_glcnt"},  GlitchCount, 0);
  endtask

  initial begin
    int fk;
    int c;
    int p0;

    Reset  = 1'b1;
    nSel   = 1'b1;
    nOE    = 1'b1;
    AddrIn = 20'h0;
    tick(); tick(); tick();
    check_all_zero("reset");
    Reset = 1'b0;
    tick(); tick(); tick(); tick();

    // Basic read
    nSel   = 1'b0;
    AddrIn = 20'hA0005;
    tick(); tick(); tick();
    nOE = 1'b0;
    watch(10, fk, c);
    $display("basic read addr=%05h valid_at=%0d pulses=%0d", 20'hA0005, fk, c);
    check_val("basic_valid_edge", fk, 4);
    check_val("basic_pulses", c, 1);
    check_val("basic_hi", AddrHi, 4'hA);
    check_val("basic_lo", AddrLo, 8'h05);
    check_val("basic_rdcnt", ReadCount, 1);
    check_val("basic_active_held", CycleActive, 1);
    nOE = 1'b1;
    tick(); tick();
    check_val("basic_active_2_after_rise", CycleActive, 1);
    tick();
    check_val("basic_active_dropped", CycleActive, 0);
    tick(); tick(); tick();

    // Glitch: raw nOE low for a single sampling edge
    nOE = 1'b0;
    tick();
    nOE = 1'b1;
    watch(6, fk, c);
    $display("glitch pulses=%0d glitch_count=%0d", c, GlitchCount);
    check_val("glitch_pulses", c, 0);
    check_val("glitch_count", GlitchCount, 1);
    check_val("glitch_hi_kept", AddrHi, 4'hA);
    check_val("glitch_lo_kept", AddrLo, 8'h05);
    check_val("glitch_rdcnt", ReadCount, 1);

    // Address settling one cycle after the strobe falls
    AddrIn = 20'h12345;
    nOE    = 1'b0;
    tick();
    AddrIn = 20'hA0005;
    watch(9, fk, c);
    fk = (fk == 0) ? 0 : fk + 1;
    $display("settle read addr=%05h valid_at=%0d pulses=%0d", 20'hA0005, fk, c);
    check_val("settle_valid_edge", fk, 5);
    check_val("settle_pulses", c, 1);
    check_val("settle_hi", AddrHi, 4'hA);
    check_val("settle_lo", AddrLo, 8'h05);
    check_val("settle_glcnt", GlitchCount, 1);
    check_val("settle_rdcnt", ReadCount, 2);
    nOE = 1'b1;
    tick(); tick(); tick(); tick();

    // Reset mid-cycle while the strobe stays low
    AddrIn = 20'h3C0F0;
    nOE    = 1'b0;
    watch(6, fk, c);
    $display("pre-reset read addr=%05h valid_at=%0d", 20'h3C0F0, fk);
    check_val("prereset_rdcnt", ReadCount, 3);
    check_val("prereset_active", CycleActive, 1);
    Reset = 1'b1;
    tick();
    check_all_zero("midreset");
    Reset = 1'b0;
    watch(10, fk, c);
    $display("post-reset held strobe pulses=%0d", c);
    check_val("postreset_no_accept", c, 0);
    check_val("postreset_rdcnt", ReadCount, 0);
    nOE = 1'b1;
    watch(4, fk, c);
    nOE = 1'b0;
    watch(6, fk, c);
    $display("post-reset fresh read addr=%05h valid_at=%0d pulses=%0d", 20'h3C0F0, fk, c);
    check_val("fresh_valid_edge", fk, 4);
    check_val("fresh_pulses", c, 1);
    check_val("fresh_hi", AddrHi, 4'h3);
    check_val("fresh_lo", AddrLo, 8'hF0);
    check_val("fresh_rdcnt", ReadCount, 1);
    nOE = 1'b1;
    tick(); tick(); tick(); tick();

    // Deselected: strobe toggles with nSel high
    nSel = 1'b1;
    tick(); tick(); tick();
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      nOE = 1'b0;
      watch(4, fk, c);
      nOE = 1'b1;
      watch(3, fk, c);
    end
    $display("deselected pulses=%0d", pulse_cnt - p0);
    check_val("desel_pulses", pulse_cnt - p0, 0);
    check_val("desel_rdcnt", ReadCount, 1);
    check_val("desel_glcnt", GlitchCount, 0);
    nSel = 1'b0;
    tick(); tick(); tick();

    // Back-to-back: 300 reads, low 4 / high 2
    p0 = pulse_cnt;
    for (int r = 0; r < 300; r++) begin
      AddrIn = 20'(r * 20'h10101);
      nOE = 1'b0;
      tick(); tick(); tick(); tick();
      nOE = 1'b1;
      tick(); tick();
      if (r == 199) begin
        check_val("b2b_rdcnt_200", ReadCount, 201);
      end
      if (r == 253) begin
        check_val("b2b_rdcnt_sat", ReadCount, 255);
      end
    end
    tick(); tick(); tick();
    $display("back-to-back pulses=%0d read_count=%0d", pulse_cnt - p0, ReadCount);
    check_val("b2b_pulses", pulse_cnt - p0, 300);
    check_val("b2b_rdcnt_final", ReadCount, 255);
    check_val("b2b_glcnt", GlitchCount, 0);
    check_val("b2b_last_lo", AddrLo, 8'(299 * 32'h10101));
    check_val("no_back_to_back_valid", consec_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
